// File: rtl/strip_pkg.sv
// Shared types and width helpers for the vertical strip extractor.
package strip_pkg;

    typedef enum logic {SCAN, EMIT} state_t;

    function automatic int unsigned idx_w(input int unsigned num_strips);
        return (num_strips <= 1) ? 1 : $clog2(num_strips);
    endfunction

    function automatic int unsigned col_w(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned num_strips);
        return $clog2(num_strips + 1);
    endfunction

    // Wide enough that lead+OFFSET+k*STRIDE never wraps.
    function automatic int unsigned tgt_w(input int unsigned width, input int unsigned offset,
                                          input int unsigned num_strips, input int unsigned stride);
        return $clog2(width + offset + num_strips * stride) + 1;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned stride,
                                     input int unsigned num_strips);
        return (stride >= 1) && (num_strips >= 1) && (width >= 2);
    endfunction

endpackage

// File: rtl/vertical_strip_extractor_if.sv
// Column input stream and strip output stream of the vertical strip extractor.
interface vertical_strip_extractor_if #(
    parameter int unsigned WIDTH      = 300,
    parameter int unsigned HEIGHT     = 200,
    parameter int unsigned NUM_STRIPS = 1
);
    localparam int unsigned IDX_W = strip_pkg::idx_w(NUM_STRIPS);
    localparam int unsigned COL_W = strip_pkg::col_w(WIDTH);

    logic              in_valid;
    logic              in_ready;
    logic [HEIGHT-1:0] in_col;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [HEIGHT-1:0] out_strip;
    logic [IDX_W-1:0]  out_idx;
    logic              out_hit;
    logic              out_last;
    logic [COL_W-1:0]  out_lead_col;
    logic              out_blank;
    logic              out_frame_err;

    modport master (
        output in_valid, in_col, in_last, out_ready,
        input  in_ready, out_valid, out_strip, out_idx, out_hit, out_last,
               out_lead_col, out_blank, out_frame_err
    );

    modport slave (
        input  in_valid, in_col, in_last, out_ready,
        output in_ready, out_valid, out_strip, out_idx, out_hit, out_last,
               out_lead_col, out_blank, out_frame_err
    );
endinterface

// File: rtl/strip_buffer.sv
// Strip register file: one column per entry plus a hit flag, sync clear, async read.
module strip_buffer #(
    parameter int unsigned HEIGHT     = 200,
    parameter int unsigned NUM_STRIPS = 1,
    parameter int unsigned IDX_W      = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [HEIGHT-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [HEIGHT-1:0] rd_data,
    output logic              rd_hit
);
    logic [HEIGHT-1:0]     mem [NUM_STRIPS];
    logic [NUM_STRIPS-1:0] hit;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < NUM_STRIPS; i++) mem[i] <= '0;
            hit <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    mem[i] <= wr_data;
                    hit[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_hit  = hit[i];
                rd_data = hit[i] ? mem[i] : '0;
            end
        end
    end
endmodule

// File: rtl/vertical_strip_extractor.sv
// Finds the leftmost non-empty column of a streamed frame, captures the strips
// at lead+OFFSET+k*STRIDE and replays them as a valid/ready burst.
module vertical_strip_extractor
    import strip_pkg::*;
#(
    parameter int unsigned WIDTH      = 300,
    parameter int unsigned HEIGHT     = 200,
    parameter int unsigned OFFSET     = 30,
    parameter int unsigned STRIDE     = 1,
    parameter int unsigned NUM_STRIPS = 1
) (
    input logic                    clk,
    input logic                    rst,
    vertical_strip_extractor_if.slave bus
);
    localparam int unsigned IDX_W = idx_w(NUM_STRIPS);
    localparam int unsigned COL_W = col_w(WIDTH);
    localparam int unsigned CNT_W = cnt_w(NUM_STRIPS);
    localparam int unsigned TGT_W = tgt_w(WIDTH, OFFSET, NUM_STRIPS, STRIDE);

    if (!params_ok(WIDTH, STRIDE, NUM_STRIPS)) begin : g_param_check
        $error("vertical_strip_extractor: need STRIDE>=1, NUM_STRIPS>=1, WIDTH>=2");
    end

    state_t            state;
    logic [COL_W-1:0]  col_cnt;
    logic [COL_W-1:0]  lead;
    logic              found;
    logic              err;
    logic [TGT_W-1:0]  target;
    logic [CNT_W-1:0]  cap_cnt;
    logic [IDX_W-1:0]  emit_k;

    logic              accept, detect, capture, at_edge, frame_end, last_k, done;
    logic [TGT_W-1:0]  eff_t;
    logic [HEIGHT-1:0] rd_data;
    logic              rd_hit;

    // On the detection beat the target register is not yet loaded, so the
    // comparison uses the freshly computed col_cnt+OFFSET instead.
    always_comb begin
        accept    = (state == SCAN) && bus.in_valid;
        detect    = accept && !found && (|bus.in_col);
        eff_t     = detect ? (TGT_W'(col_cnt) + TGT_W'(OFFSET)) : target;
        capture   = accept && (found || detect) && (cap_cnt < CNT_W'(NUM_STRIPS))
                    && (TGT_W'(col_cnt) == eff_t);
        at_edge   = (col_cnt == COL_W'(WIDTH - 1));
        frame_end = accept && (bus.in_last || at_edge);
        last_k    = (emit_k == IDX_W'(NUM_STRIPS - 1));
        done      = (state == EMIT) && bus.out_ready && last_k;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SCAN;
            col_cnt <= '0;
            lead    <= '0;
            found   <= 1'b0;
            err     <= 1'b0;
            target  <= '0;
            cap_cnt <= '0;
            emit_k  <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (accept) begin
                        if (detect) begin
                            found <= 1'b1;
                            lead  <= col_cnt;
                        end
                        if (capture) begin
                            cap_cnt <= cap_cnt + 1'b1;
                            target  <= eff_t + TGT_W'(STRIDE);
                        end else if (detect) begin
                            target <= eff_t;
                        end
                        if (frame_end) begin
                            err    <= bus.in_last != at_edge;
                            emit_k <= '0;
                            state  <= EMIT;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (last_k) begin
                            col_cnt <= '0;
                            lead    <= '0;
                            found   <= 1'b0;
                            err     <= 1'b0;
                            target  <= '0;
                            cap_cnt <= '0;
                            emit_k  <= '0;
                            state   <= SCAN;
                        end else begin
                            emit_k <= emit_k + 1'b1;
                        end
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    strip_buffer #(
        .HEIGHT     (HEIGHT),
        .NUM_STRIPS (NUM_STRIPS),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk     (clk),
        .clr     (rst || done),
        .wr_en   (capture),
        .wr_idx  (IDX_W'(cap_cnt)),
        .wr_data (bus.in_col),
        .rd_idx  (emit_k),
        .rd_data (rd_data),
        .rd_hit  (rd_hit)
    );

    always_comb begin
        bus.in_ready      = (state == SCAN);
        bus.out_valid     = (state == EMIT);
        bus.out_idx       = emit_k;
        bus.out_strip     = bus.out_valid ? rd_data : '0;
        bus.out_hit       = bus.out_valid && rd_hit;
        bus.out_last      = bus.out_valid && last_k;
        bus.out_lead_col  = bus.out_valid ? lead : '0;
        bus.out_blank     = bus.out_valid && !found;
        bus.out_frame_err = bus.out_valid && err;
    end
endmodule

// File: tb/tb_vertical_strip_extractor.sv
// Drives two extractor variants (OFFSET=2/STRIDE=1 and OFFSET=0/STRIDE=2) with the same frames.
module tb_vertical_strip_extractor;

    typedef struct packed {
        logic [3:0] strip;
        logic       idx;
        logic       hit;
        logic       last;
        logic [2:0] lead;
        logic       blank;
        logic       err;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_col;
    logic       in_last;
    logic       out_ready;

    logic [3:0] cols [8];
    int         last_pos;
    beat_t      got [2][2];
    beat_t      exp [2][2];
    int         n_pass;
    int         n_total;

    vertical_strip_extractor_if #(.WIDTH(8), .HEIGHT(4), .NUM_STRIPS(2)) ia ();
    vertical_strip_extractor_if #(.WIDTH(8), .HEIGHT(4), .NUM_STRIPS(2)) ib ();

    assign ia.in_valid  = in_valid;
    assign ia.in_col    = in_col;
    assign ia.in_last   = in_last;
    assign ia.out_ready = out_ready;
    assign ib.in_valid  = in_valid;
    assign ib.in_col    = in_col;
    assign ib.in_last   = in_last;
    assign ib.out_ready = out_ready;

    vertical_strip_extractor #(
        .WIDTH(8), .HEIGHT(4), .OFFSET(2), .STRIDE(1), .NUM_STRIPS(2)
    ) dut_a (.clk(clk), .rst(rst), .bus(ia));

    vertical_strip_extractor #(
        .WIDTH(8), .HEIGHT(4), .OFFSET(0), .STRIDE(2), .NUM_STRIPS(2)
    ) dut_b (.clk(clk), .rst(rst), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected beats from the frame rules: frame ends at in_last or column 7,
    // lead is the first non-zero column, strip k sits at lead+off+k*stride.
    task automatic model();
        int end_i, lead, t, off, str;
        end_i = (last_pos >= 0 && last_pos < 7) ? last_pos : 7;
        lead = -1;
        for (int i = 0; i <= end_i; i++)
            if (lead < 0 && cols[i] != 4'h0) lead = i;
        for (int d = 0; d < 2; d++) begin
            off = (d == 0) ? 2 : 0;
            str = (d == 0) ? 1 : 2;
            for (int k = 0; k < 2; k++) begin
                t = lead + off + k * str;
                exp[d][k].hit   = (lead >= 0) && (t <= end_i);
                exp[d][k].strip = exp[d][k].hit ? cols[t] : 4'h0;
                exp[d][k].idx   = 1'(k);
                exp[d][k].last  = (k == 1);
                exp[d][k].lead  = (lead < 0) ? 3'd0 : 3'(lead);
                exp[d][k].blank = (lead < 0);
                exp[d][k].err   = (last_pos != 7);
            end
        end
    endtask

    task automatic gen_frame();
        int lp;
        lp = $urandom_range(0, 8);
        for (int i = 0; i < 8; i++) begin
            if (i < lp) cols[i] = 4'h0;
            else if (i == lp) cols[i] = 4'($urandom_range(1, 15));
            else cols[i] = 4'($urandom_range(0, 15));
        end
    endtask

    function automatic beat_t snap(input int d);
        beat_t b;
        if (d == 0) begin
            b.strip = ia.out_strip; b.idx = ia.out_idx; b.hit = ia.out_hit;
            b.last = ia.out_last; b.lead = ia.out_lead_col;
            b.blank = ia.out_blank; b.err = ia.out_frame_err;
        end else begin
            b.strip = ib.out_strip; b.idx = ib.out_idx; b.hit = ib.out_hit;
            b.last = ib.out_last; b.lead = ib.out_lead_col;
            b.blank = ib.out_blank; b.err = ib.out_frame_err;
        end
        return b;
    endfunction

    task automatic drive_frame(input int nbeats, input bit bubbles, output int stuck);
        bit r;
        int w;
        stuck = 0;
        for (int i = 0; i < nbeats; i++) begin
            if (bubbles) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_col   = cols[i];
            in_last  = (i == last_pos);
            w = 0;
            do begin
                @(negedge clk);
                r = ia.in_ready && ib.in_ready;
                @(posedge clk); #1;
                w++;
            end while (!r && w < 50);
            if (!r) stuck++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for the first 3 valid cycles
    task automatic collect(input int mode, output int tmo, output int wc, output int unst,
                           output int rb);
        beat_t cur [2];
        beat_t prev [2];
        bit stalled;
        int j, cyc, vc;
        tmo = 0; wc = 0; unst = 0; rb = 0; j = 0; cyc = 0; vc = 0; stalled = 0;
        for (int d = 0; d < 2; d++) for (int k = 0; k < 2; k++) got[d][k] = '1;
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        while (j < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ia.out_valid) begin
                vc++;
                cur[0] = snap(0);
                cur[1] = snap(1);
                if (!ib.out_valid) unst++;
                if (ia.in_ready || ib.in_ready) rb++;
                if (stalled && (cur[0] !== prev[0] || cur[1] !== prev[1])) unst++;
                if (out_ready) begin
                    got[0][j] = cur[0];
                    got[1][j] = cur[1];
                    j++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                end
                prev = cur;
            end else if (j == 0) begin
                wc++;
            end else begin
                unst++;
            end
            @(posedge clk); #1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (vc >= 3);
            endcase
        end
        tmo = (j < 2);
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_col = 4'h0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({(d == 0) ? ia.in_ready : ib.in_ready, (d == 0) ? ia.out_valid : ib.out_valid} !== 2'b10)
                $display("FAIL reset_handshake dut%0d got ready/valid=%b%b exp 10", d,
                         (d == 0) ? ia.in_ready : ib.in_ready, (d == 0) ? ia.out_valid : ib.out_valid);
            else n_pass++;
            n_total++;
            if (snap(d) !== beat_t'(0))
                $display("FAIL reset_outputs dut%0d got=%h exp=0", d, snap(d));
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int stuck, tmo, wc, unst, rb;
        cols = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
        last_pos = 7;
        model();
        drive_frame(8, 0, stuck);
        collect(0, tmo, wc, unst, rb);
        n_total++;
        if (stuck + tmo + unst + rb !== 0)
            $display("FAIL basic_protocol got stuck=%0d tmo=%0d unst=%0d rb=%0d exp all 0", stuck, tmo, unst, rb);
        else n_pass++;
        n_total++;
        if (wc !== 0) $display("FAIL basic_latency got %0d idle cycles exp 0", wc);
        else n_pass++;
        n_total++;
        if (got[0][0].strip !== 4'h4 || got[0][1].strip !== 4'h8 || got[0][0].lead !== 3'd3)
            $display("FAIL basic_anchor got strips %h %h lead %0d exp 4 8 lead 3",
                     got[0][0].strip, got[0][1].strip, got[0][0].lead);
        else n_pass++;
        for (int d = 0; d < 2; d++) for (int j = 0; j < 2; j++) begin
            n_total++;
            if (got[d][j] !== exp[d][j])
                $display("FAIL basic dut%0d beat%0d got=%h exp=%h", d, j, got[d][j], exp[d][j]);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if (!ia.in_ready || ia.out_valid || !ib.in_ready || ib.out_valid)
            $display("FAIL idle_after_burst got ready=%b valid=%b exp ready=1 valid=0", ia.in_ready, ia.out_valid);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_frame(input string name, input int mode, input bit bubbles);
        int stuck, tmo, wc, unst, rb;
        model();
        drive_frame((last_pos >= 0 && last_pos < 7) ? last_pos + 1 : 8, bubbles, stuck);
        collect(mode, tmo, wc, unst, rb);
        n_total++;
        if (stuck + tmo + unst + rb !== 0 || wc !== 0)
            $display("FAIL %s_protocol got stuck=%0d tmo=%0d unst=%0d rb=%0d wc=%0d exp all 0",
                     name, stuck, tmo, unst, rb, wc);
        else n_pass++;
        for (int d = 0; d < 2; d++) for (int j = 0; j < 2; j++) begin
            n_total++;
            if (got[d][j] !== exp[d][j])
                $display("FAIL %s dut%0d beat%0d got=%h exp=%h", name, d, j, got[d][j], exp[d][j]);
            else n_pass++;
        end
    endtask

    task automatic test_blank();
        for (int i = 0; i < 8; i++) cols[i] = 4'h0;
        last_pos = 7;
        test_frame("blank", 0, 0);
    endtask

    task automatic test_edge();
        cols = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h3};
        last_pos = 7;
        test_frame("edge", 0, 0);
    endtask

    task automatic test_short();
        cols = '{4'h0, 4'h9, 4'h2, 4'hA, 4'h6, 4'hC, 4'hD, 4'hE};
        last_pos = 4;
        test_frame("short", 0, 0);
    endtask

    task automatic test_long();
        gen_frame();
        last_pos = -1;
        test_frame("long", 1, 1);
    endtask

    task automatic test_stall();
        cols = '{4'h0, 4'h3, 4'h0, 4'h7, 4'hB, 4'h1, 4'h2, 4'h4};
        last_pos = 7;
        test_frame("stall", 2, 0);
    endtask

    task automatic test_mid_reset();
        int stuck;
        cols = '{4'h0, 4'h6, 4'h3, 4'h5, 4'h1, 4'h1, 4'h1, 4'h1};
        last_pos = -1;
        drive_frame(4, 0, stuck);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (!ia.in_ready || ia.out_valid || !ib.in_ready || ib.out_valid || stuck != 0)
            $display("FAIL mid_reset_state got ready=%b valid=%b stuck=%0d exp 1 0 0",
                     ia.in_ready, ia.out_valid, stuck);
        else n_pass++;
        @(posedge clk); #1;
        cols = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h9, 4'h8};
        last_pos = 7;
        test_frame("mid_reset", 0, 0);
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 24; n++) begin
            gen_frame();
            r = $urandom_range(0, 5);
            last_pos = (r == 0) ? -1 : (r == 1) ? $urandom_range(0, 6) : 7;
            test_frame("random", 1, 1);
        end
    endtask

    task automatic test_back_to_back();
        beat_t saved [2][2];
        beat_t got1 [2][2];
        int s1, s2, tmo1, wc1, un1, rb1, tmo2, wc2, un2, rb2;
        gen_frame();
        last_pos = 7;
        model();
        saved = exp;
        drive_frame(8, 0, s1);
        gen_frame();
        model();
        fork
            begin
                collect(1, tmo1, wc1, un1, rb1);
                got1 = got;
            end
            drive_frame(8, 0, s2);
        join
        collect(0, tmo2, wc2, un2, rb2);
        n_total++;
        if (s1 + s2 + tmo1 + un1 + rb1 + tmo2 + un2 + rb2 + wc1 + wc2 !== 0)
            $display("FAIL b2b_protocol got s=%0d/%0d tmo=%0d/%0d unst=%0d/%0d rb=%0d/%0d wc=%0d/%0d exp all 0",
                     s1, s2, tmo1, tmo2, un1, un2, rb1, rb2, wc1, wc2);
        else n_pass++;
        for (int d = 0; d < 2; d++) for (int j = 0; j < 2; j++) begin
            n_total++;
            if (got1[d][j] !== saved[d][j])
                $display("FAIL b2b_first dut%0d beat%0d got=%h exp=%h", d, j, got1[d][j], saved[d][j]);
            else n_pass++;
            n_total++;
            if (got[d][j] !== exp[d][j])
                $display("FAIL b2b_second dut%0d beat%0d got=%h exp=%h", d, j, got[d][j], exp[d][j]);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_blank();
        test_edge();
        test_short();
        test_long();
        test_stall();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vertical_strip_extractor.md
Name: vertical_strip_extractor

Overview:
- Streaming, parametrised successor to the combinational leftmost-column/strip finder in the digit-preprocessing path.
- Accepts a binary image one column per beat and locates the leftmost non-empty column (the "lead").
- Captures NUM_STRIPS columns at lead+OFFSET+k*STRIDE, then emits them as a valid/ready stream to the feature/NN input stage.
- Also reports blank-image and frame-length errors.

Parameters:
- WIDTH, 300: columns per frame.
- HEIGHT, 200: pixels per column (bits per beat).
- OFFSET, 30: distance from the lead column to the first strip.
- STRIDE, 1: column spacing between successive strips; must be ≥1.
- NUM_STRIPS, 1: number of strips captured per frame; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input column valid.
- in_ready  out  1  block can accept a column.
- in_col  in  HEIGHT  column pixels; bit r is row r.
- in_last  in  1  marks the final column of the frame.
- out_valid  out  1  strip beat valid.
- out_ready  in  1  downstream accepts the strip beat.
- out_strip  out  HEIGHT  captured column; 0 if not hit.
- out_idx  out  IDX_W  strip number k; IDX_W = max(1, clog2(NUM_STRIPS)).
- out_hit  out  1  strip k lay inside the frame and was captured.
- out_last  out  1  final strip beat of the frame.
- out_lead_col  out  COL_W  lead column index; COL_W = clog2(WIDTH). 0 if blank.
- out_blank  out  1  no non-zero column in the frame.
- out_frame_err  out  1  frame length did not equal WIDTH.

Behaviour:
- Reset (sync, active-high; any cycle including mid-frame or mid-emit): state=SCAN, col_cnt=0, found=0, all buffer entries and hit bits cleared, err=0. Outputs after reset: in_ready=1, out_valid=0, out_last=0, out_strip=0, out_idx=0, out_hit=0, out_lead_col=0, out_blank=0, out_frame_err=0. The partial frame is discarded.
- States: SCAN, EMIT.
- SCAN:
  - in_ready=1; a beat is accepted when in_valid&in_ready.
  - On the first accepted beat with |in_col=1 while found=0: found←1, lead←col_cnt.
  - Effective target T: the same cycle as detection uses col_cnt+OFFSET; afterwards the target register holds lead+OFFSET+k*STRIDE for the next uncaptured k.
  - When the accepted col_cnt==T and k<NUM_STRIPS: buf[k]←in_col, hit[k]←1, k++, target+=STRIDE.
  - OFFSET=0 therefore captures the lead column itself on the detection beat.
  - Target arithmetic uses TGT_W = clog2(WIDTH+OFFSET+NUM_STRIPS*STRIDE)+1 bits, so it never wraps. Targets ≥ frame length never hit.
  - Frame end: an accepted beat with in_last=1 OR col_cnt==WIDTH-1.
    - If in_last and col_cnt!=WIDTH-1: err←1 (short frame).
    - If col_cnt==WIDTH-1 and !in_last: err←1 (long/unframed).
    - In both cases → EMIT next cycle; col_cnt is not advanced.
- EMIT:
  - in_ready=0. out_valid=1 from the first cycle, with out_idx=k, starting at k=0.
  - out_strip = buf[k] if hit[k], else 0. out_hit = hit[k]. out_last = (k==NUM_STRIPS-1).
  - out_lead_col, out_blank (=!found) and out_frame_err are constant for the whole burst.
  - All outputs stay stable while out_valid&!out_ready.
  - On a handshake, k advances. On the out_last handshake: clear buffers/counters → SCAN, so in_ready=1 the next cycle (one idle input cycle per frame).
- Latency: first strip beat appears 1 cycle after the frame-end beat is accepted.
- A blank frame still emits NUM_STRIPS beats, all with out_hit=0.
- Strips that run past the frame edge emit out_hit=0.
- Back-to-back frames: in_valid held high across EMIT is simply stalled; no beats are lost.

Decomposition:
- Package strip_pkg holds:
  - state enum (SCAN, EMIT);
  - helper function for TGT_W/IDX_W;
  - parameter legality assertions: STRIDE≥1, NUM_STRIPS≥1, WIDTH≥2.
- One sub-module, strip_buffer: NUM_STRIPS×HEIGHT register file with a hit bit per entry, a write port (wr_en, wr_idx, wr_data), a combinational read port (rd_idx), and a synchronous clear.
- The top level holds the FSM, lead detection and target counter.

Test Plan (WIDTH=8, HEIGHT=4, OFFSET=2, STRIDE=1, NUM_STRIPS=2 unless stated):
- Columns 0,0,0,1,2,4,8,F, in_last on beat 7, out_ready=1 → lead=3; beats (idx0,strip 4,hit1) then (idx1,strip 8,hit1,last); blank=0, err=0.
- All-zero frame → 2 beats, strip 0, hit 0, blank=1, lead=0, err=0.
- Lead at column 6 → idx0 targets col 8, out of range → both beats hit=0, blank=0, lead=6.
- in_last asserted on beat 4 (short frame), lead=1 → strips cols 3,4 captured, err=1, EMIT starts the cycle after beat 4.
- out_ready low for 3 cycles on beat 0 → outputs held stable, in_ready=0 throughout; then two beats in order.
- rst pulsed mid-scan after the lead was found, then a clean frame → only the new frame is reported. Also OFFSET=0, STRIDE=2 variant: lead=3 captures cols 3 and 5.
